// File: rtl/alpha_blend_unit.sv
// Per-pixel alpha compositor: reads the destination colour, blends it with the
// source RGBA by source alpha, writes it back, and forwards end-of-frame.
module alpha_blend_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] pixel_number,
  input  logic        pixel_ready,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic [7:0]  a,
  input  logic [7:0]  read_r,
  input  logic [7:0]  read_g,
  input  logic [7:0]  read_b,
  input  logic        frame_ready,
  output logic        o_frame_ready,
  output logic        read,
  output logic        write,
  output logic [7:0]  write_r,
  output logic [7:0]  write_g,
  output logic [7:0]  write_b
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        frame_fire;
  logic        pending;
  logic [7:0]  r_p0, g_p0, b_p0, a_p0;
  logic [18:0] pix_num_p0;
  logic        unused_pix_num;

  // floor((alpha*src + (255-alpha)*dst) / 255); x <= 65025 keeps the
  // shift-based divide exact and the intermediate inside 16 bits.
  function automatic logic [7:0] blend(input logic [7:0] alpha,
                                       input logic [7:0] src,
                                       input logic [7:0] dst);
    logic [15:0] x;
    x = 16'(alpha) * 16'(src) + 16'(8'd255 - alpha) * 16'(dst);
    return 8'((x + (x >> 8) + 16'd1) >> 8);
  endfunction

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    frame_fire = 1'b0;
    case (state)
      IDLE: begin
        if (pixel_ready) begin
          accept     = 1'b1;
          state_next = READ;
        end else if (pending) begin
          frame_fire = 1'b1;
        end
      end
      READ:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_frame_ready = frame_fire;

  // The pixel index travels with the pixel but nothing here consumes it.
  assign unused_pix_num = ^pix_num_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      read    <= 1'b0;
      write   <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      read    <= accept;
      write   <= (state == READ);
      pending <= frame_ready | (pending & ~frame_fire);
    end
  end

  // Capture stage: source pixel latched on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p0       <= '0;
      g_p0       <= '0;
      b_p0       <= '0;
      a_p0       <= '0;
      pix_num_p0 <= '0;
    end else if (accept) begin
      r_p0       <= r;
      g_p0       <= g;
      b_p0       <= b;
      a_p0       <= a;
      pix_num_p0 <= pixel_number;
    end
  end

  // Blend stage: destination sampled at the end of READ
  always_ff @(posedge clk) begin
    if (reset) begin
      write_r <= '0;
      write_g <= '0;
      write_b <= '0;
    end else if (state == READ) begin
      write_r <= blend(a_p0, r_p0, read_r);
      write_g <= blend(a_p0, g_p0, read_g);
      write_b <= blend(a_p0, b_p0, read_b);
    end
  end

endmodule

// File: tb/tb_alpha_blend_unit.sv
// Scoreboard bench for alpha_blend_unit: a frame-buffer model answers reads,
// expected blends are queued at pixel issue and popped at the write strobe.
module tb_alpha_blend_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] pixel_number = '0;
  logic        pixel_ready = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0, a = '0;
  logic [7:0]  dst_r = '0, dst_g = '0, dst_b = '0;
  logic [7:0]  read_r, read_g, read_b;
  logic        frame_ready = 1'b0;
  logic        o_frame_ready, read, write;
  logic [7:0]  write_r, write_g, write_b;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  // Frame buffer returns garbage outside the read cycle to expose mistimed sampling.
  assign read_r = read ? dst_r : ~dst_r;
  assign read_g = read ? dst_g : ~dst_g;
  assign read_b = read ? dst_b : ~dst_b;

  alpha_blend_unit dut (
    .clk(clk), .reset(reset), .pixel_number(pixel_number), .pixel_ready(pixel_ready),
    .r(r), .g(g), .b(b), .a(a),
    .read_r(read_r), .read_g(read_g), .read_b(read_b),
    .frame_ready(frame_ready), .o_frame_ready(o_frame_ready),
    .read(read), .write(write),
    .write_r(write_r), .write_g(write_g), .write_b(write_b)
  );

  function automatic logic [7:0] model(input int alpha, input int src, input int dst);
    return 8'((alpha * src + (255 - alpha) * dst) / 255);
  endfunction

  task automatic drive_pixel(input logic [7:0] sr, sg, sb, sa, dr, dg, db);
    r = sr; g = sg; b = sb; a = sa;
    dst_r = dr; dst_g = dg; dst_b = db;
    pixel_number = 19'($urandom_range(0, 307199));
    pixel_ready = 1'b1;
    exp_q.push_back({model(sa, sr, dr), model(sa, sg, dg), model(sa, sb, db)});
  endtask

  // Full transaction from an IDLE negedge; returns at the following IDLE negedge.
  task automatic pixel_txn(input logic [7:0] sr, sg, sb, sa, dr, dg, db, input string nm);
    logic [23:0] e;
    drive_pixel(sr, sg, sb, sa, dr, dg, db);
    @(negedge clk);
    pixel_ready = 1'b0;
    vectors++;
    if ({read, write} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s read_cycle: read/write=%b required 10", nm, {read, write});
    end
    @(negedge clk);
    vectors++;
    if ({read, write} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s write_cycle: read/write=%b required 01", nm, {read, write});
    end
    e = '0;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: queue empty at write", nm);
    end else begin
      e = exp_q.pop_front();
      if ({write_r, write_g, write_b} !== e) begin
        miscompares++;
        $display("FAIL %s data: got %h required %h", nm, {write_r, write_g, write_b}, e);
      end
    end
    @(negedge clk);
    vectors++;
    if ({read, write, write_r, write_g, write_b} !== {2'b00, e}) begin
      miscompares++;
      $display("FAIL %s hold: got %b/%h required 00/%h", nm, {read, write},
               {write_r, write_g, write_b}, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_frame_ready, read, write, write_r, write_g, write_b} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0",
               {o_frame_ready, read, write, write_r, write_g, write_b});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_frame_ready, read, write} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: strobes %b required 000", {o_frame_ready, read, write});
    end
  endtask

  task automatic test_blend();
    pixel_txn(8'd128, 8'd64, 8'd192, 8'd17, 8'd1, 8'd2, 8'd3, "blend_a17");
    vectors++;
    if ({write_r, write_g, write_b} !== {8'd9, 8'd6, 8'd15}) begin
      miscompares++;
      $display("FAIL blend_const: got %h required 09060f", {write_r, write_g, write_b});
    end
    pixel_txn(8'd255, 8'd0, 8'd100, 8'd128, 8'd0, 8'd255, 8'd200, "blend_a128");
  endtask

  task automatic test_alpha_limits();
    pixel_txn(8'd200, 8'd10, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, "alpha_255");
    vectors++;
    if ({write_r, write_g, write_b} !== {8'd200, 8'd10, 8'd255}) begin
      miscompares++;
      $display("FAIL alpha_255_const: got %h required c80aff", {write_r, write_g, write_b});
    end
    pixel_txn(8'd250, 8'd251, 8'd252, 8'd0, 8'd7, 8'd8, 8'd9, "alpha_0");
    vectors++;
    if ({write_r, write_g, write_b} !== {8'd7, 8'd8, 8'd9}) begin
      miscompares++;
      $display("FAIL alpha_0_const: got %h required 070809", {write_r, write_g, write_b});
    end
    pixel_txn(8'd255, 8'd255, 8'd255, 8'd254, 8'd0, 8'd255, 8'd1, "alpha_254");
  endtask

  task automatic test_busy_ignore();
    int reads, writes;
    logic [23:0] e;
    drive_pixel(8'd40, 8'd80, 8'd120, 8'd100, 8'd200, 8'd150, 8'd100);
    @(negedge clk);
    r = 8'hff; g = 8'h00; b = 8'hff; a = 8'hff;   // second pulse during READ
    reads = read; writes = write;
    @(negedge clk);
    pixel_ready = 1'b0;
    reads += read; writes += write;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hx;
    vectors++;
    if ({write_r, write_g, write_b} !== e) begin
      miscompares++;
      $display("FAIL busy_data: got %h required %h", {write_r, write_g, write_b}, e);
    end
    repeat (5) begin
      @(negedge clk);
      reads += read; writes += write;
    end
    vectors++;
    if (reads != 1 || writes != 1) begin
      miscompares++;
      $display("FAIL busy_strobes: reads=%0d writes=%0d required 1/1", reads, writes);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    drive_pixel(8'd10, 8'd20, 8'd30, 8'd60, 8'd90, 8'd80, 8'd70);
    @(negedge clk);
    r = 8'd220; g = 8'd110; b = 8'd55; a = 8'd200;  // next pixel, accepted after WRITE
    exp_q.push_back({model(200, 220, 5), model(200, 110, 6), model(200, 55, 7)});
    @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hx;
    vectors++;
    if ({write, write_r, write_g, write_b} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL b2b_first: got %b/%h required 1/%h", write, {write_r, write_g, write_b}, e);
    end
    dst_r = 8'd5; dst_g = 8'd6; dst_b = 8'd7;
    @(negedge clk);
    vectors++;
    if ({read, write} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: read/write=%b required 00", {read, write});
    end
    @(negedge clk);
    pixel_ready = 1'b0;
    vectors++;
    if (read !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_reaccept: read=%b required 1", read);
    end
    @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hx;
    vectors++;
    if ({write, write_r, write_g, write_b} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL b2b_second: got %b/%h required 1/%h", write, {write_r, write_g, write_b}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_frame();
    logic [3:0] seen;
    // idle: pulse forwarded in the next cycle, for one cycle
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    seen[0] = o_frame_ready;
    @(negedge clk);
    seen[1] = o_frame_ready;
    vectors++;
    if (seen[1:0] !== 2'b01) begin
      miscompares++;
      $display("FAIL frame_idle: pulse seq %b required 01", seen[1:0]);
    end
    // during READ: held until the cycle after WRITE
    drive_pixel(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    @(negedge clk);
    pixel_ready = 1'b0;
    frame_ready = 1'b1;
    seen[0] = o_frame_ready;
    @(negedge clk);
    frame_ready = 1'b0;
    seen[1] = o_frame_ready;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    seen[2] = o_frame_ready;
    @(negedge clk);
    seen[3] = o_frame_ready;
    vectors++;
    if (seen !== 4'b0100) begin
      miscompares++;
      $display("FAIL frame_busy: seq(msb last) %b required 0100", seen);
    end
    // simultaneous with accept: pixel wins, pulse follows its WRITE
    drive_pixel(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    frame_ready = 1'b1;
    seen[0] = o_frame_ready;
    @(negedge clk);
    pixel_ready = 1'b0;
    frame_ready = 1'b0;
    seen[1] = o_frame_ready;
    @(negedge clk);
    seen[2] = o_frame_ready;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    seen[3] = o_frame_ready;
    vectors++;
    if (seen !== 4'b1000) begin
      miscompares++;
      $display("FAIL frame_with_accept: seq(msb last) %b required 1000", seen);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_during_read();
    r = 8'd33; g = 8'd44; b = 8'd55; a = 8'd66;
    pixel_ready = 1'b1;
    @(negedge clk);
    pixel_ready = 1'b0;
    vectors++;
    if (read !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_read_start: read=%b required 1", read);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({o_frame_ready, read, write, write_r, write_g, write_b} !== 27'd0) begin
      miscompares++;
      $display("FAIL rst_mid_read: got %h required 0",
               {o_frame_ready, read, write, write_r, write_g, write_b});
    end
    @(negedge clk);
    vectors++;
    if ({read, write} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_no_write: read/write=%b required 00", {read, write});
    end
  endtask

  task automatic test_random();
    logic [7:0] sa;
    for (int i = 0; i < 16; i++) begin
      sa = (i == 3) ? 8'd0 : (i == 7) ? 8'd255 : 8'($urandom);
      pixel_txn(8'($urandom), 8'($urandom), 8'($urandom), sa,
                8'($urandom), 8'($urandom), 8'($urandom), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_blend();
    test_alpha_limits();
    test_busy_ignore();
    test_back_to_back();
    test_frame();
    test_reset_during_read();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
